// File: rtl/mem_resp_pkg.sv
// Shared types and sizing helpers for the
// data-memory responder and its word RAM.
package mem_resp_pkg;

  localparam int WORD_W = 32;
  localparam int CNT_W  = 4;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_e;

  function automatic int clog2(input int n);
    int w;
    w = 0;
    while ((1 << w) < n) w++;
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/data_mem_responder_word_ram.sv
// Single-port word array: synchronous write,
// read data registered only when a read is requested.
module word_ram
  import mem_resp_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic              i_re,
  input  logic [AW-1:0]     i_addr,
  input  logic [WORD_W-1:0] i_wdata,
  output logic [WORD_W-1:0] o_rdata
);

  logic [WORD_W-1:0] r_mem [DEPTH];
  logic [WORD_W-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_addr] <= i_wdata;
    if (i_re) r_rdata <= r_mem[i_addr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/data_mem_responder.sv
// MEM-stage load/store responder: latches one
// request, waits LATENCY cycles, pulses a response.
module data_mem_responder
  import mem_resp_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic              req_write,
  input  logic [WORD_W-1:0] req_addr,
  input  logic [WORD_W-1:0] req_wdata,
  output logic              req_ready,
  output logic              resp_valid,
  output logic [WORD_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic              stall
);

  localparam int IDX_W = clog2(DEPTH_WORDS);
  localparam logic [CNT_W-1:0] LAT_M1 =
    CNT_W'(LATENCY - 1);

  state_e            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_write;
  logic [WORD_W-1:0] r_addr;
  logic [WORD_W-1:0] r_wdata;
  logic              r_valid;
  logic              r_err;
  logic              r_load_ok;

  logic              w_err;
  logic              w_done;
  logic              w_we;
  logic              w_re;
  logic [IDX_W-1:0]  w_idx;
  logic [WORD_W-1:0] w_ram_rdata;

  assign w_err = (|r_addr[1:0]) ||
    ((r_addr >> 2) >= WORD_W'(DEPTH_WORDS));
  assign w_idx = r_addr[IDX_W+1:2];

  // Array is touched only on the WAIT->RESP edge,
  // and never while reset is asserted.
  assign w_done = rst && (r_state == WAIT) &&
    (r_cnt == '0);
  assign w_we = w_done && r_write && !w_err;
  assign w_re = w_done && !r_write && !w_err;

  word_ram #(
    .DEPTH (DEPTH_WORDS),
    .AW    (IDX_W)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_we),
    .i_re    (w_re),
    .i_addr  (w_idx),
    .i_wdata (r_wdata),
    .o_rdata (w_ram_rdata)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_write   <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_valid   <= 1'b0;
      r_err     <= 1'b0;
      r_load_ok <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (req_valid) begin
            r_write <= req_write;
            r_addr  <= req_addr;
            r_wdata <= req_wdata;
            r_cnt   <= LAT_M1;
            r_state <= WAIT;
          end
        end
        WAIT: begin
          if (r_cnt == '0) begin
            r_state   <= RESP;
            r_valid   <= 1'b1;
            r_err     <= w_err;
            r_load_ok <= w_re;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        RESP: r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  // RAM read register only moves on loads, so
  // gating it holds rdata until the next response.
  assign resp_rdata = r_load_ok ? w_ram_rdata : '0;
  assign resp_valid = r_valid;
  assign resp_err   = r_err;
  assign req_ready  = (r_state == IDLE);
  assign stall = ((r_state == IDLE) && req_valid) ||
    (r_state == WAIT);

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
Multi-cycle data-memory responder at the far end of the pipeline's MEM-stage load/store interface. It accepts one word read or write request per transaction through a valid/ready handshake, holds the request for a programmable latency, then returns a one-cycle response. While a request is outstanding it drives a stall that the hazard logic uses to freeze PC, IF/ID and the downstream stages.

Parameters:
DEPTH_WORDS, 256, number of 32-bit words in the backing array (power of two)
LATENCY, 3, WAIT-state cycles between acceptance and response (legal range 1..15)

Ports:
clk  in  1  system clock; all state updates on its rising edge
rst  in  1  synchronous, active-low reset
req_valid  in  1  MEM stage presents a request (MemRead or MemWrite asserted)
req_write  in  1  1 = store, 0 = load
req_addr  in  32  byte address from ALU result
req_wdata  in  32  store data (forwarded Rt value)
req_ready  out  1  responder can accept a request this cycle
resp_valid  out  1  one-cycle pulse: transaction complete
resp_rdata  out  32  load data; valid only with resp_valid
resp_err  out  1  with resp_valid: address misaligned or out of range
stall  out  1  pipeline must hold; feeds the hazard logic

Behaviour:
- Reset (rst=0 at a clock edge): state=IDLE, counter=0, latched request cleared, resp_valid=0, resp_rdata=0, resp_err=0. The array contents are not reset. Reset during WAIT or RESP abandons the transaction: no write is performed and no response is produced.
- FSM states: IDLE, WAIT, RESP.
  - IDLE: req_ready=1. On req_valid=1, latch write, addr and wdata, set counter=LATENCY-1, and go to WAIT.
  - WAIT: req_ready=0. If counter==0, go to RESP; otherwise decrement the counter. WAIT lasts exactly LATENCY cycles.
  - RESP: resp_valid=1 for exactly one cycle, then go to IDLE. No request is accepted in RESP; the next acceptance occurs in IDLE at the earliest one cycle later.
- Timing: acceptance at edge T; resp_valid is high during cycle T+LATENCY+1. Throughput is one transaction per LATENCY+2 cycles.
- Array access happens on the WAIT-to-RESP transition edge:
  - Store: mem[addr[9:2]] (index width is log2(DEPTH_WORDS)) is written with the latched wdata. resp_rdata=0.
  - Load: resp_rdata is registered from mem[index].
- Error: the request is in error if addr[1:0]!=0 or addr>>2 >= DEPTH_WORDS. In that case resp_err=1, no write occurs, and resp_rdata=0.
- stall = (state==IDLE && req_valid) || state==WAIT. It is combinational, so the pipeline freezes in the same cycle a request appears. It is low in RESP, so the pipeline advances on the edge ending the RESP cycle and captures resp_rdata.
- The request inputs are ignored outside IDLE. Changes to req_valid or req_addr during WAIT do not affect the latched transaction.
- With req_valid held high across RESP (the next instruction is also a memory op), the responder returns to IDLE and accepts that request on the following cycle. No request is lost or duplicated.
- resp_rdata and resp_err hold their values after the RESP cycle until the next response, but they are meaningful only with resp_valid.

Decomposition:
- Package mem_resp_pkg:
  - state enum {IDLE, WAIT, RESP}
  - WORD_W=32
  - CNT_W=4
  - index-width function clog2(DEPTH_WORDS)
- Sub-module word_ram (DEPTH_WORDS x 32): synchronous write, registered read, single port. It owns the array; the responder owns the FSM, the counter and the error check.

Test Plan:
- Reset mid-WAIT: accept store 0xDEADBEEF to 0x10, assert rst=0 during the second WAIT cycle → no resp_valid, and a later load of 0x10 returns the prior contents (not 0xDEADBEEF). Outputs are 0 the cycle after reset.
- Store then load, LATENCY=3: store 0xDEADBEEF to 0x10 at edge T → stall high in cycles T..T+3, resp_valid at T+4 with resp_err=0. Load 0x10 → resp_rdata=0xDEADBEEF, resp_valid exactly LATENCY+1 cycles after acceptance.
- Back-to-back: req_valid held through two loads (0x0, 0x4) → exactly two resp_valid pulses, 5 cycles apart, with the correct data each. req_ready=0 in RESP.
- Misaligned/out-of-range: store to 0x13, then store to 0x400 (DEPTH 256) → each gives resp_err=1 and resp_rdata=0, and a subsequent load of 0x10 is unchanged.
- Input churn: change req_addr and drop req_valid during WAIT → the response reflects the originally latched address, with no extra transaction.
- LATENCY=1 build: acceptance at T → resp_valid at T+2, stall high only in cycles T and T+1.
